perf_snapshot_tx: RTL and testbench
===================================

# perf_snapshot_tx

Read-side companion to the RV32I `Pipeline_top` performance counters: it samples `cycle_count` and `instr_retired` on request and streams a fixed 10-byte report frame over a byte-wide valid/ready interface. It sits beside the pipeline, typically feeding a UART or debug FIFO, and replaces end-of-simulation hierarchical peeking with an on-chip, synthesizable report path.

## Interface
Parameters:
- `HEADER`, default 8'hA5: first byte of every frame.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `cycle_count` in 32: pipeline cycle counter.
- `instr_retired` in 32: pipeline retired-instruction counter.
- `snap_req` in 1: snapshot request, sampled each cycle.
- `tx_data` out 8: current frame byte.
- `tx_valid` out 1: `tx_data` is valid.
- `tx_ready` in 1: sink accepts byte when high with `tx_valid`.
- `busy` out 1: frame capture or transmission in progress.
- `frame_done` out 1: one-cycle pulse after the last byte is accepted.
- `overrun` out 1: sticky flag, a `snap_req` arrived while busy.

## Operation
- Frame byte order: `HEADER`, cycle[31:24], cycle[23:16], cycle[15:8], cycle[7:0], instr[31:24], instr[23:16], instr[15:8], instr[7:0], checksum.
- Checksum is the XOR of bytes 1–8; the header is excluded.
- FSM states: IDLE, SEND, DONE.
  - IDLE: `snap_req`=1 latches both counters into 32-bit snapshot registers, clears the byte index to 0, then goes to SEND.
  - SEND: `tx_valid`=1 and `tx_data` = frame[index]. On `tx_valid && tx_ready`: index increments; if index was 9, go to DONE.
  - DONE: `frame_done`=1 for one cycle, then return to IDLE.
- `busy` = (state != IDLE).
- `snap_req` in SEND or DONE is dropped, sets `overrun`=1, and leaves the snapshot unchanged. `overrun` clears only on reset.
- The checksum accumulates incrementally as bytes are accepted, or is computed combinationally from the snapshot. Either implementation must give identical output.
- Byte index is 4 bits and never exceeds 9.

## Timing
- Reset (`rst`=0 at a clock edge) forces, at that edge:
  - `tx_valid`=0, `tx_data`=0, `busy`=0, `frame_done`=0, `overrun`=0
  - state IDLE, index 0, snapshots 0
- A reset mid-frame aborts the frame. Nothing resumes afterwards.
- `snap_req` high at edge N means counters are captured at edge N. `tx_valid` rises after edge N, showing the header.
- `tx_data` and `tx_valid` are registered. While `tx_valid`=1 and `tx_ready`=0, `tx_data` holds stable.
- Each byte takes a minimum of 1 cycle. With `tx_ready` tied high, a frame takes 10 cycles in SEND plus 1 in DONE.
- The earliest next accepted `snap_req` is the cycle after DONE, when state is IDLE. `snap_req` during the DONE cycle counts as overrun.
- `tx_ready` without `tx_valid` is ignored.

## Configuration
- `PERF_SNAP_DELTA_EN` defined: bytes 1–8 carry deltas since the previous snapshot.
  - Deltas are (current − previous) mod 2^32.
  - Previous values are held in extra 32-bit registers, reset to 0. The first frame after reset therefore equals the absolute values.
  - Header becomes `HEADER` ^ 8'h01, so frames are self-describing.
- Not defined: bytes 1–8 carry absolute counter values, and no previous-value registers exist.

## Structure
- Shared package `perf_pkg` holds:
  - the state enum (IDLE/SEND/DONE)
  - `PERF_FRAME_LEN` = 10
  - `PERF_HDR_DELTA_XOR` = 8'h01
- One sub-module is natural: `perf_frame_mux`, a combinational selector mapping (index, snapshots) to the byte value. The FSM, handshake and flags stay in the top module.

## Test plan
- Basic frame: cycle=0x00000014, instr=0x00000010, `snap_req` pulse, `tx_ready`=1 -> bytes A5 00 00 00 14 00 00 00 10 04. `frame_done` pulses once, 11 cycles after capture.
- Backpressure: same stimulus, `tx_ready` toggling 1-0-0-1 pattern -> identical byte sequence, `tx_data` stable during every stall, no byte duplicated or skipped.
- Snapshot isolation: counters keep changing every cycle during SEND -> transmitted values equal those at the capture edge. Checksum is consistent with them.
- Overrun: `snap_req` at byte 3 and again in the DONE cycle -> frame unaffected, `overrun`=1 and stays 1. A `snap_req` after IDLE starts a new frame.
- Reset mid-frame: `rst`=0 at byte 5 -> next cycle `tx_valid`=0, `busy`=0, `overrun`=0. A new `snap_req` yields a full frame starting with header A5.
- Delta mode (`PERF_SNAP_DELTA_EN`): snapshot at (100, 40), then at (0x0000012C, 0x00000064) -> second frame header A4, payload 00 00 00 C8 00 00 00 3C, checksum F4.

Source files
------------

// File: rtl/perf_snapshot_tx_pkg.sv
// Shared types and constants for the performance-counter snapshot transmitter.
package perf_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      DONE = 2'd2
   } perf_state_e;

   localparam int unsigned PERF_FRAME_LEN = 10;
   localparam int unsigned PERF_IDX_W     = 4;
   localparam logic [7:0]  PERF_HDR_DELTA_XOR = 8'h01;
   localparam logic [PERF_IDX_W-1:0] PERF_LAST_IDX = PERF_IDX_W'(PERF_FRAME_LEN - 1);

   typedef struct packed {
      logic [31:0] cyc;
      logic [31:0] ins;
   } perf_snap_t;

   // XOR of the eight payload bytes; the header never takes part.
   function automatic logic [7:0] perf_xor_fold(input perf_snap_t s);
      return s.cyc[31:24] ^ s.cyc[23:16] ^ s.cyc[15:8] ^ s.cyc[7:0] ^
             s.ins[31:24] ^ s.ins[23:16] ^ s.ins[15:8] ^ s.ins[7:0];
   endfunction

endpackage

// File: rtl/perf_snapshot_tx_if.sv
// Byte-wide valid/ready stream carrying the snapshot report frame.
interface perf_snapshot_tx_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/perf_frame_mux.sv
// Maps a frame byte index and the captured payload onto the outgoing byte.
module perf_frame_mux
   import perf_pkg::*;
(
   input  logic [PERF_IDX_W-1:0] idx,
   input  logic [7:0]            header,
   input  perf_snap_t            payload,
   output logic [7:0]            frame_byte_c
);

   always_comb begin
      frame_byte_c = 8'h00;
      case (idx)
         4'd0:    frame_byte_c = header;
         4'd1:    frame_byte_c = payload.cyc[31:24];
         4'd2:    frame_byte_c = payload.cyc[23:16];
         4'd3:    frame_byte_c = payload.cyc[15:8];
         4'd4:    frame_byte_c = payload.cyc[7:0];
         4'd5:    frame_byte_c = payload.ins[31:24];
         4'd6:    frame_byte_c = payload.ins[23:16];
         4'd7:    frame_byte_c = payload.ins[15:8];
         4'd8:    frame_byte_c = payload.ins[7:0];
         4'd9:    frame_byte_c = perf_xor_fold(payload);
         default: frame_byte_c = 8'h00;
      endcase
   end

endmodule

// File: rtl/perf_snapshot_tx.sv
// Captures cycle/instret counters on request and streams a 10-byte report frame.
// PERF_SNAP_DELTA_EN: payload carries deltas since the previous snapshot, header ^ 8'h01.
module perf_snapshot_tx
   import perf_pkg::*;
#(
   parameter logic [7:0] HEADER = 8'hA5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [31:0]               cycle_count,
   input  logic [31:0]               instr_retired,
   input  logic                      snap_req,
   perf_snapshot_tx_if.master        tx,
   output logic                      busy,
   output logic                      frame_done,
   output logic                      overrun
);

   perf_state_e           state_q, state_d;
   logic [PERF_IDX_W-1:0] idx_q, idx_d;
   perf_snap_t            snap_q, snap_d;
   logic                  overrun_d;
   logic                  tx_valid_d;
   logic [7:0]            tx_data_d;
   logic                  busy_d;
   logic                  frame_done_d;
   logic                  accept_c;
   logic [7:0]            header_c;
   perf_snap_t            payload_c;
   logic [7:0]            frame_byte_c;

   assign accept_c = tx.tx_valid && tx.tx_ready;

`ifdef PERF_SNAP_DELTA_EN
   perf_snap_t prev_q, prev_d;
   logic       capture_c;

   assign capture_c = (state_q == IDLE) && snap_req;
   assign header_c  = HEADER ^ PERF_HDR_DELTA_XOR;
   assign payload_c = '{cyc: snap_d.cyc - prev_d.cyc, ins: snap_d.ins - prev_d.ins};

   // Old snapshot becomes the delta reference at the moment a new one is taken.
   always_comb begin
      prev_d = prev_q;
      if (capture_c) prev_d = snap_q;
   end

   always_ff @(posedge clk) begin
      if (!rst) prev_q <= '0;
      else      prev_q <= prev_d;
   end
`else
   assign header_c  = HEADER;
   assign payload_c = snap_d;
`endif

   // Byte is looked up from next-state index/snapshot so tx_data can be registered.
   perf_frame_mux u_mux (
      .idx          (idx_d),
      .header       (header_c),
      .payload      (payload_c),
      .frame_byte_c (frame_byte_c)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      snap_d    = snap_q;
      overrun_d = overrun;
      case (state_q)
         IDLE: begin
            if (snap_req) begin
               state_d = SEND;
               idx_d   = '0;
               snap_d  = '{cyc: cycle_count, ins: instr_retired};
            end
         end
         SEND: begin
            if (snap_req) overrun_d = 1'b1;
            if (accept_c) begin
               if (idx_q == PERF_LAST_IDX) begin
                  state_d = DONE;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + PERF_IDX_W'(1);
               end
            end
         end
         DONE: begin
            if (snap_req) overrun_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tx_valid_d   = (state_d == SEND);
      tx_data_d    = tx_valid_d ? frame_byte_c : 8'h00;
      busy_d       = (state_d != IDLE);
      frame_done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         snap_q      <= '0;
         tx.tx_valid <= 1'b0;
         tx.tx_data  <= 8'h00;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         snap_q      <= snap_d;
         tx.tx_valid <= tx_valid_d;
         tx.tx_data  <= tx_data_d;
         busy        <= busy_d;
         frame_done  <= frame_done_d;
         overrun     <= overrun_d;
      end
   end

endmodule

// File: tb/tb_perf_snapshot_tx.sv
// Directed bench for perf_snapshot_tx: table of frames plus overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_perf_snapshot_tx;

`ifdef PERF_SNAP_DELTA_EN
   localparam logic [7:0] EXP_HDR = 8'hA4;
`else
   localparam logic [7:0] EXP_HDR = 8'hA5;
`endif

   typedef struct {
      logic [31:0]      cyc;
      logic [31:0]      ins;
      logic [3:0]       pat;
      logic [0:9][7:0]  exp;
   } vec_t;

   localparam int NV = 5;

   logic        clk;
   logic        rst;
   logic [31:0] cycle_count;
   logic [31:0] instr_retired;
   logic        snap_req;
   logic        busy;
   logic        frame_done;
   logic        overrun;

   int          n_vec;
   int          n_bad;
   logic        exp_ovr;
   vec_t        vecs [NV];

   perf_snapshot_tx_if bus ();

   perf_snapshot_tx #(.HEADER(8'hA5)) dut (
      .clk           (clk),
      .rst           (rst),
      .cycle_count   (cycle_count),
      .instr_retired (instr_retired),
      .snap_req      (snap_req),
      .tx            (bus),
      .busy          (busy),
      .frame_done    (frame_done),
      .overrun       (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      exp_ovr = 1'b0;
   endtask

   // Captures (c,i), then walks the frame byte by byte under the given ready pattern.
   // req_at: byte index at which snap_req is raised; rst_at: byte index at which reset is hit.
   task automatic run_frame(input logic [31:0] c, input logic [31:0] i, input logic [3:0] pat,
                            input logic [0:9][7:0] exp, input int req_at, input bit req_in_done,
                            input int rst_at, input string tag);
      int k;
      int cyc_n;
      bit acc;
      k = 0;
      cyc_n = 0;
      @(posedge clk); #1;
      cycle_count   = c;
      instr_retired = i;
      snap_req      = 1'b1;
      bus.tx_ready  = 1'b0;
      @(posedge clk); #1;
      snap_req = 1'b0;
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      while (k < 10 && cyc_n < 200) begin
         if (k == rst_at) begin
            rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            check({tag, "_rst_valid"}, 32'(bus.tx_valid), 32'd0);
            check({tag, "_rst_data"},  32'(bus.tx_data), 32'd0);
            check({tag, "_rst_busy"},  32'(busy), 32'd0);
            check({tag, "_rst_ovr"},   32'(overrun), 32'd0);
            check({tag, "_rst_done"},  32'(frame_done), 32'd0);
            exp_ovr = 1'b0;
            bus.tx_ready = 1'b0;
            return;
         end
         check($sformatf("%s_valid%0d", tag, k), 32'(bus.tx_valid), 32'd1);
         check($sformatf("%s_byte%0d", tag, k), 32'(bus.tx_data), 32'(exp[k]));
         check($sformatf("%s_nodone%0d", tag, k), 32'(frame_done), 32'd0);
         bus.tx_ready  = pat[2'(cyc_n)];
         snap_req      = (k == req_at);
         if (snap_req) exp_ovr = 1'b1;
         cycle_count   = $urandom;
         instr_retired = $urandom;
         acc = bus.tx_ready;
         @(posedge clk); #1;
         cyc_n++;
         if (acc) k++;
      end
      snap_req     = 1'b0;
      bus.tx_ready = 1'b0;
      check({tag, "_bytes_sent"}, 32'(k), 32'd10);
      if (pat == 4'hF) check({tag, "_send_cycles"}, 32'(cyc_n), 32'd10);
      check({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
      check({tag, "_done_valid"}, 32'(bus.tx_valid), 32'd0);
      check({tag, "_done_busy"},  32'(busy), 32'd1);
      snap_req = req_in_done;
      if (req_in_done) exp_ovr = 1'b1;
      @(posedge clk); #1;
      snap_req = 1'b0;
      check({tag, "_done_fall"}, 32'(frame_done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_idle_valid"}, 32'(bus.tx_valid), 32'd0);
      check({tag, "_overrun"}, 32'(overrun), 32'(exp_ovr));
   endtask

   initial begin
      logic [0:9][7:0] exp_f2;
      n_vec         = 0;
      n_bad         = 0;
      exp_ovr       = 1'b0;
      rst           = 1'b0;
      snap_req      = 1'b0;
      cycle_count   = 32'd0;
      instr_retired = 32'd0;
      bus.tx_ready  = 1'b0;

      vecs[0] = '{cyc: 32'h0000_0014, ins: 32'h0000_0010, pat: 4'hF,
                  exp: {EXP_HDR, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00, 8'h10, 8'h04}};
      vecs[1] = '{cyc: 32'h0000_0014, ins: 32'h0000_0010, pat: 4'b1001,
                  exp: {EXP_HDR, 8'h00, 8'h00, 8'h00, 8'h14, 8'h00, 8'h00, 8'h00, 8'h10, 8'h04}};
      vecs[2] = '{cyc: 32'hDEAD_BEEF, ins: 32'h1234_5678, pat: 4'hF,
                  exp: {EXP_HDR, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h2A}};
      vecs[3] = '{cyc: 32'hFFFF_FFFF, ins: 32'h0000_0000, pat: 4'b0110,
                  exp: {EXP_HDR, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[4] = '{cyc: 32'h0102_0304, ins: 32'h8040_2010, pat: 4'b0110,
                  exp: {EXP_HDR, 8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h40, 8'h20, 8'h10, 8'hF4}};

`ifdef PERF_SNAP_DELTA_EN
      exp_f2 = {8'hA4, 8'h00, 8'h00, 8'h00, 8'hC8, 8'h00, 8'h00, 8'h00, 8'h3C, 8'hF4};
`else
      exp_f2 = {8'hA5, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h00, 8'h00, 8'h00, 8'h64, 8'h49};
`endif

      repeat (3) @(posedge clk);
      #1;
      check("reset_valid", 32'(bus.tx_valid), 32'd0);
      check("reset_data",  32'(bus.tx_data), 32'd0);
      check("reset_busy",  32'(busy), 32'd0);
      check("reset_done",  32'(frame_done), 32'd0);
      check("reset_ovr",   32'(overrun), 32'd0);
      rst = 1'b1;

      // Ready with no valid must not move anything.
      bus.tx_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("idle_ready_valid", 32'(bus.tx_valid), 32'd0);
      check("idle_ready_busy",  32'(busy), 32'd0);
      bus.tx_ready = 1'b0;

      for (int v = 0; v < NV; v++) begin
         do_reset();
         run_frame(vecs[v].cyc, vecs[v].ins, vecs[v].pat, vecs[v].exp, -1, 1'b0, -1,
                   $sformatf("vec%0d", v));
      end

      // Overrun during SEND and DONE, then a second frame (delta reference in delta builds).
      do_reset();
      run_frame(32'd100, 32'd40, 4'hF,
                {EXP_HDR, 8'h00, 8'h00, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h28, 8'h4C},
                3, 1'b1, -1, "ovr1");
      run_frame(32'h0000_012C, 32'h0000_0064, 4'hF, exp_f2, -1, 1'b0, -1, "ovr2");
      check("ovr_sticky", 32'(overrun), 32'd1);

      // Reset in the middle of a frame, then a clean frame.
      do_reset();
      run_frame(32'h0000_0014, 32'h0000_0010, 4'hF, vecs[0].exp, 2, 1'b0, 5, "rstmid");
      repeat (2) @(posedge clk);
      #1;
      check("rstmid_no_resume", 32'(bus.tx_valid), 32'd0);
      run_frame(32'h0000_0014, 32'h0000_0010, 4'b1001, vecs[0].exp, -1, 1'b0, -1, "after_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
